// File: rtl/dcache_ctrl_pkg.sv
// Shared geometry, state encoding and byte-select helper for the data cache controller.
package dcache_ctrl_pkg;

    localparam int TAG_W      = 3;
    localparam int IDX_W      = 3;
    localparam int OFF_W      = 2;
    localparam int BLOCK_W    = 32;
    localparam int NUM_BLOCKS = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        FETCH      = 2'd2,
        UPDATE     = 2'd3
    } state_t;

    function automatic logic [7:0] select_byte(input logic [BLOCK_W-1:0] blk,
                                               input logic [OFF_W-1:0]   off);
        return blk[{off, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Data/tag/valid/dirty storage with combinational hit compare and byte select.
module dcache_array
    import dcache_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [TAG_W-1:0]   tag,
    input  logic [IDX_W-1:0]   index,
    input  logic [OFF_W-1:0]   offset,
    input  logic               byte_we,
    input  logic [7:0]         byte_data,
    input  logic               fill_we,
    input  logic [IDX_W-1:0]   fill_index,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [BLOCK_W-1:0] fill_data,
    output logic               hit,
    output logic [7:0]         rd_byte,
    output logic               victim_dirty,
    output logic [TAG_W-1:0]   victim_tag,
    output logic [BLOCK_W-1:0] victim_data
);

    logic [BLOCK_W-1:0]    data_mem [NUM_BLOCKS];
    logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] valid;
    logic [NUM_BLOCKS-1:0] dirty;

    // Contents need no reset; only the valid/dirty flags qualify them.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[fill_index] <= fill_data;
            tag_mem[fill_index]  <= fill_tag;
        end else if (byte_we) begin
            data_mem[index][{offset, 3'b000} +: 8] <= byte_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill_we) begin
            valid[fill_index] <= 1'b1;
            dirty[fill_index] <= 1'b0;
        end else if (byte_we) begin
            dirty[index] <= 1'b1;
        end
    end

    assign hit          = valid[index] && (tag_mem[index] == tag);
    assign rd_byte      = select_byte(data_mem[index], offset);
    assign victim_dirty = valid[index] && dirty[index];
    assign victim_tag   = tag_mem[index];
    assign victim_data  = data_mem[index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller: miss FSM and memory-side registers.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
(
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     READ,
    input  logic                     WRITE,
    input  logic [7:0]               ADDRESS,
    input  logic [7:0]               WRITEDATA,
    output logic [7:0]               READDATA,
    output logic                     BUSYWAIT,
    output logic                     MEM_READ,
    output logic                     MEM_WRITE,
    output logic [TAG_W+IDX_W-1:0]   MEM_ADDRESS,
    output logic [BLOCK_W-1:0]       MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0]       MEM_READDATA,
    input  logic                     MEM_BUSYWAIT
);

    state_t             state;
    state_t             state_next;
    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   index;
    logic [OFF_W-1:0]   offset;
    logic [TAG_W-1:0]   miss_tag;
    logic [IDX_W-1:0]   miss_index;
    logic [BLOCK_W-1:0] fill_block;
    logic               request;
    logic               hit;
    logic               byte_we;
    logic               fill_we;
    logic [7:0]         rd_byte;
    logic               victim_dirty;
    logic [TAG_W-1:0]   victim_tag;
    logic [BLOCK_W-1:0] victim_data;

    assign tag     = ADDRESS[7:5];
    assign index   = ADDRESS[4:2];
    assign offset  = ADDRESS[1:0];
    assign request = READ | WRITE;
    assign byte_we = (state == IDLE) && WRITE && hit;
    assign fill_we = (state == UPDATE);

    dcache_array u_array (
        .clk          (CLK),
        .rst          (RESET),
        .tag          (tag),
        .index        (index),
        .offset       (offset),
        .byte_we      (byte_we),
        .byte_data    (WRITEDATA),
        .fill_we      (fill_we),
        .fill_index   (miss_index),
        .fill_tag     (miss_tag),
        .fill_data    (fill_block),
        .hit          (hit),
        .rd_byte      (rd_byte),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .victim_data  (victim_data)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (request && !hit) state_next = victim_dirty ? WRITE_BACK : FETCH;
            WRITE_BACK: if (!MEM_BUSYWAIT)   state_next = FETCH;
            FETCH:      if (!MEM_BUSYWAIT)   state_next = UPDATE;
            UPDATE:     state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Memory requests are registered off the next state so they hold steady for the whole state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
        end else begin
            state     <= state_next;
            MEM_READ  <= (state_next == FETCH);
            MEM_WRITE <= (state_next == WRITE_BACK);
            if (state == IDLE && state_next == WRITE_BACK) begin
                MEM_ADDRESS   <= {victim_tag, index};
                MEM_WRITEDATA <= victim_data;
            end else if (state == IDLE && state_next == FETCH) begin
                MEM_ADDRESS <= {tag, index};
            end else if (state == WRITE_BACK && state_next == FETCH) begin
                MEM_ADDRESS <= {miss_tag, miss_index};
            end
        end
    end

    // The miss target is frozen on leaving IDLE, so a dropped request still fills the right line.
    always_ff @(posedge CLK) begin
        if (state == IDLE) begin
            miss_tag   <= tag;
            miss_index <= index;
        end
        if (state == FETCH && !MEM_BUSYWAIT) begin
            fill_block <= MEM_READDATA;
        end
    end

    assign BUSYWAIT = ((state == IDLE) && request && !hit) || (state != IDLE);
    assign READDATA = ((state == IDLE) && READ && hit) ? rd_byte : 8'h00;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed requests, queued expectations, decoupled monitor.
module tb_dcache_ctrl;

    typedef struct packed {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } mtx_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [7:0]  ADDRESS = 8'h00;
    logic [7:0]  WRITEDATA = 8'h00;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    logic [31:0] mem [64];
    int          mem_cnt = 0;
    int          mem_lat = 5;
    int          checks = 0;
    int          errors = 0;
    mtx_t        mem_q [$];
    logic [7:0]  rd_q [$];

    dcache_ctrl dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Block memory: busy for mem_lat cycles after each request starts, then completes.
    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt < mem_lat);
    assign MEM_READDATA = mem[MEM_ADDRESS];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[6'h01] = 32'h44332211;
        mem[6'h09] = 32'hDDCCBBAA;
        mem[6'h11] = 32'h88776655;
        forever begin
            @(posedge CLK);
            if (!(MEM_READ || MEM_WRITE) || !MEM_BUSYWAIT) mem_cnt <= 0;
            else                                           mem_cnt <= mem_cnt + 1;
            if (MEM_WRITE && !MEM_BUSYWAIT) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops a memory expectation at each new request, a load byte at each completed load.
    initial begin
        logic [1:0] prev;
        logic [1:0] cur;
        mtx_t       m;
        logic [7:0] e;
        prev = 2'b00;
        forever begin
            @(negedge CLK);
            cur = {MEM_WRITE, MEM_READ};
            if (cur == 2'b11) check("mem_exclusive", 32'(cur), 32'h1);
            if (cur != 2'b00 && cur != prev) begin
                if (mem_q.size() == 0) begin
                    check("mem_unexpected", 32'(cur), 32'h0);
                end else begin
                    m = mem_q.pop_front();
                    check("mem_kind", 32'(MEM_WRITE), 32'(m.wr));
                    check("mem_addr", 32'(MEM_ADDRESS), 32'(m.addr));
                    if (m.wr) check("mem_wdata", MEM_WRITEDATA, m.data);
                end
            end
            prev = cur;
            if (READ && !WRITE && !BUSYWAIT) begin
                if (rd_q.size() == 0) begin
                    check("read_unexpected", 32'(READDATA), 32'h0);
                end else begin
                    e = rd_q.pop_front();
                    check("readdata", 32'(READDATA), 32'(e));
                end
            end
        end
    end

    task automatic push_mem(input logic wr, input logic [5:0] addr, input logic [31:0] data);
        mtx_t m;
        m.wr = wr;
        m.addr = addr;
        m.data = data;
        mem_q.push_back(m);
    endtask

    // Issues one request from just after a rising edge and holds it until it completes.
    task automatic do_req(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wd, input logic [7:0] exp_rd,
                          input int exp_stall, input string name);
        int stall;
        stall = 0;
        if (rd && !wr) rd_q.push_back(exp_rd);
        READ = rd;
        WRITE = wr;
        ADDRESS = addr;
        WRITEDATA = wd;
        @(negedge CLK);
        while (BUSYWAIT && stall < 100) begin
            stall++;
            @(negedge CLK);
        end
        check(name, 32'(stall), 32'(exp_stall));
        @(posedge CLK);
        #1;
        READ = 1'b0;
        WRITE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2 RESET = 1'b1;
        #1;
        check("rst_busywait", 32'(BUSYWAIT), 32'h0);
        check("rst_mem_read", 32'(MEM_READ), 32'h0);
        check("rst_mem_write", 32'(MEM_WRITE), 32'h0);
        check("rst_mem_addr", 32'(MEM_ADDRESS), 32'h0);
        check("rst_mem_wdata", MEM_WRITEDATA, 32'h0);
        check("rst_readdata", 32'(READDATA), 32'h0);
        READ = 1'b1;
        ADDRESS = 8'h05;
        #1;
        check("rst_busy_on_req", 32'(BUSYWAIT), 32'h1);
        READ = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(posedge CLK);
        #1;

        // Clean miss fill, then hits on other offsets of the same block.
        push_mem(1'b0, 6'h01, 32'h0);
        do_req(1'b1, 1'b0, 8'h05, 8'h00, 8'h22, 8, "stall_clean_miss");
        do_req(1'b1, 1'b0, 8'h04, 8'h00, 8'h11, 0, "stall_hit_04");
        do_req(1'b1, 1'b0, 8'h07, 8'h00, 8'h44, 0, "stall_hit_07");

        // Store hit then reload.
        do_req(1'b0, 1'b1, 8'h06, 8'hAB, 8'h00, 0, "stall_write_hit");
        do_req(1'b1, 1'b0, 8'h06, 8'h00, 8'hAB, 0, "stall_read_after_write");

        // Dirty conflict miss: write-back then fetch.
        push_mem(1'b1, 6'h01, 32'h44AB2211);
        push_mem(1'b0, 6'h09, 32'h0);
        do_req(1'b1, 1'b0, 8'h26, 8'h00, 8'hCC, 14, "stall_dirty_miss");

        // Reset during fetch abandons it and clears valid.
        push_mem(1'b0, 6'h01, 32'h0);
        READ = 1'b1;
        ADDRESS = 8'h05;
        repeat (3) @(negedge CLK);
        check("fetch_active", 32'(MEM_READ), 32'h1);
        #2 RESET = 1'b1;
        #1;
        check("rst_drop_mem_read", 32'(MEM_READ), 32'h0);
        check("rst_drop_mem_write", 32'(MEM_WRITE), 32'h0);
        check("rst_drop_mem_addr", 32'(MEM_ADDRESS), 32'h0);
        check("rst_mid_busy_req", 32'(BUSYWAIT), 32'h1);
        READ = 1'b0;
        #1;
        check("rst_mid_busy_idle", 32'(BUSYWAIT), 32'h0);
        check("rst_mid_readdata", 32'(READDATA), 32'h0);
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(posedge CLK);
        #1;
        push_mem(1'b0, 6'h01, 32'h0);
        do_req(1'b1, 1'b0, 8'h05, 8'h00, 8'h22, 8, "stall_after_reset");

        // READ+WRITE together on a miss, dropped mid-fetch.
        push_mem(1'b0, 6'h11, 32'h0);
        READ = 1'b1;
        WRITE = 1'b1;
        ADDRESS = 8'h47;
        WRITEDATA = 8'h5A;
        repeat (3) @(negedge CLK);
        check("dual_miss_busy", 32'(BUSYWAIT), 32'h1);
        check("dual_miss_fetch", 32'(MEM_READ), 32'h1);
        READ = 1'b0;
        WRITE = 1'b0;
        n = 0;
        while (BUSYWAIT && n < 50) begin
            n++;
            @(negedge CLK);
        end
        check("dropped_req_idle", 32'(BUSYWAIT), 32'h0);
        @(posedge CLK);
        #1;
        do_req(1'b1, 1'b0, 8'h47, 8'h00, 8'h88, 0, "stall_dropped_line_valid");
        do_req(1'b1, 1'b1, 8'h47, 8'h5A, 8'h00, 0, "stall_dual_hit_write");
        do_req(1'b1, 1'b0, 8'h47, 8'h00, 8'h5A, 0, "stall_read_dual_write");

        // Evicting that line shows it was left dirty by the combined request.
        push_mem(1'b1, 6'h11, 32'h5A776655);
        push_mem(1'b0, 6'h09, 32'h0);
        do_req(1'b1, 1'b0, 8'h27, 8'h00, 8'hDD, 14, "stall_dirty_miss_2");

        repeat (3) @(negedge CLK);
        check("mem_q_drained", 32'(mem_q.size()), 32'h0);
        check("rd_q_drained", 32'(rd_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
